// File: rtl/checkout_pkg.sv
// Shared types and helpers for the checkout lane: FSM state encoding,
// UPC bit positions and the saturating counter increment.
package checkout_pkg;

   // Lane FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      ALARM = 2'd2,
      TOTAL = 2'd3
   } state_t;

   // Bit positions inside item_upc {M,U,P,C}
   localparam int UPC_M = 3;
   localparam int UPC_U = 2;
   localparam int UPC_P = 1;
   localparam int UPC_C = 0;

   // Saturating increment for a counter of the given width. Works on a
   // 64-bit carrier so one function serves every counter width; callers
   // zero-extend in and truncate the result back to their own width.
   function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                           input logic        inc,
                                           input int          width);
      logic [63:0] max_val;
      max_val = (64'd1 << width) - 64'd1;
      if (inc && (val < max_val)) return val + 64'd1;
      return val;
   endfunction

endpackage

// File: rtl/item_classifier.sv
// Combinational item classifier: decodes a 4-bit UPC {M,U,P,C} into the
// discounted and stolen attributes used by the checkout lane.
module item_classifier
   import checkout_pkg::*;
(
   input  logic [3:0] upc_i,
   output logic       disc_o,
   output logic       stl_o
);

   logic m, u, p, c;

   assign m = upc_i[UPC_M];
   assign u = upc_i[UPC_U];
   assign p = upc_i[UPC_P];
   assign c = upc_i[UPC_C];

   // Discounted: promo bit, or a U-coded item carrying the coupon bit
   assign disc_o = p | (u & c);

   // Stolen: untagged U item without promo/member mark, or no valid tag at all
   assign stl_o = (u & ~(p | m)) | ~(m | u | c);

endmodule

// File: rtl/checkout_register.sv
// Checkout lane: accepts scanned items over valid/ready, classifies each
// one, keeps saturating per-session counts, latches a theft alarm at
// ALARM_THRESH stolen items and reports session totals for one cycle.
module checkout_register
   import checkout_pkg::*;
#(
   parameter int CNT_W        = 8,
   parameter int ALARM_THRESH = 3
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             done,
   input  logic             clear_alarm,
   input  logic             item_valid,
   input  logic [3:0]       item_upc,
   output logic             item_ready,
   output logic             busy,
   output logic             disc_flag,
   output logic             stl_flag,
   output logic [CNT_W-1:0] item_count,
   output logic [CNT_W-1:0] disc_count,
   output logic [CNT_W-1:0] stl_count,
   output logic             alarm,
   output logic             total_valid
);

   localparam logic [CNT_W-1:0] THRESH = CNT_W'(ALARM_THRESH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] item_cnt_q, item_cnt_d;
   logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
   logic [CNT_W-1:0] stl_cnt_q,  stl_cnt_d;
   logic             disc_flag_q, disc_flag_d;
   logic             stl_flag_q,  stl_flag_d;

   logic is_disc, is_stl;
   logic accept;

   item_classifier u_classifier (
      .upc_i  (item_upc),
      .disc_o (is_disc),
      .stl_o  (is_stl)
   );

   // Only SCAN consumes items; elsewhere the scanner holds its item
   assign accept = item_valid & (state_q == SCAN);

   // Next-state and counter update logic for the lane FSM
   always_comb begin
      state_d     = state_q;
      item_cnt_d  = item_cnt_q;
      disc_cnt_d  = disc_cnt_q;
      stl_cnt_d   = stl_cnt_q;
      disc_flag_d = 1'b0;
      stl_flag_d  = 1'b0;

      case (state_q)
         IDLE: begin
            // Counts from the previous session stay visible until a new start
            if (start) begin
               item_cnt_d = '0;
               disc_cnt_d = '0;
               stl_cnt_d  = '0;
               state_d    = SCAN;
            end
         end

         SCAN: begin
            if (accept) begin
               item_cnt_d  = CNT_W'(sat_inc(64'(item_cnt_q), 1'b1,    CNT_W));
               disc_cnt_d  = CNT_W'(sat_inc(64'(disc_cnt_q), is_disc, CNT_W));
               stl_cnt_d   = CNT_W'(sat_inc(64'(stl_cnt_q),  is_stl,  CNT_W));
               disc_flag_d = is_disc;
               stl_flag_d  = is_stl;
            end
            // Only a stolen accept can trip the alarm, so after clear_alarm the
            // lane keeps scanning clean items even though stl_count is already
            // at or above the threshold. The alarm wins over a same-cycle done.
            if (accept && is_stl && (stl_cnt_d >= THRESH)) begin
               state_d = ALARM;
            end else if (done) begin
               state_d = TOTAL;
            end
         end

         ALARM: begin
            if (clear_alarm) state_d = SCAN;
         end

         TOTAL: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and counter registers; reset abandons any open session
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         item_cnt_q  <= '0;
         disc_cnt_q  <= '0;
         stl_cnt_q   <= '0;
         disc_flag_q <= 1'b0;
         stl_flag_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         item_cnt_q  <= item_cnt_d;
         disc_cnt_q  <= disc_cnt_d;
         stl_cnt_q   <= stl_cnt_d;
         disc_flag_q <= disc_flag_d;
         stl_flag_q  <= stl_flag_d;
      end
   end

   assign item_ready  = (state_q == SCAN);
   assign busy        = (state_q != IDLE);
   assign alarm       = (state_q == ALARM);
   assign total_valid = (state_q == TOTAL);
   assign disc_flag   = disc_flag_q;
   assign stl_flag    = stl_flag_q;
   assign item_count  = item_cnt_q;
   assign disc_count  = disc_cnt_q;
   assign stl_count   = stl_cnt_q;

endmodule

// File: tb/tb_checkout_register.sv
// Bench for checkout_register: two lanes (8-bit and 2-bit counters) share one
// stimulus stream; a session-level model predicts every output each cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_checkout_register;

   localparam int TH = 3;

   logic       clk = 1'b0;
   logic       reset, start, done, clear_alarm, item_valid;
   logic [3:0] item_upc;

   logic       a_ready, a_busy, a_df, a_sf, a_alarm, a_tv;
   logic [7:0] a_item, a_disc, a_stl;
   logic       b_ready, b_busy, b_df, b_sf, b_alarm, b_tv;
   logic [1:0] b_item, b_disc, b_stl;

   checkout_register #(.CNT_W(8), .ALARM_THRESH(TH)) dut_a (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .clear_alarm(clear_alarm), .item_valid(item_valid), .item_upc(item_upc),
      .item_ready(a_ready), .busy(a_busy), .disc_flag(a_df), .stl_flag(a_sf),
      .item_count(a_item), .disc_count(a_disc), .stl_count(a_stl),
      .alarm(a_alarm), .total_valid(a_tv));

   checkout_register #(.CNT_W(2), .ALARM_THRESH(TH)) dut_b (
      .clk(clk), .reset(reset), .start(start), .done(done),
      .clear_alarm(clear_alarm), .item_valid(item_valid), .item_upc(item_upc),
      .item_ready(b_ready), .busy(b_busy), .disc_flag(b_df), .stl_flag(b_sf),
      .item_count(b_item), .disc_count(b_disc), .stl_count(b_stl),
      .alarm(b_alarm), .total_valid(b_tv));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   localparam int S_IDLE = 0, S_SCAN = 1, S_ALARM = 2, S_TOTAL = 3;
   int m_st[2];
   int m_item[2], m_disc[2], m_stl[2];
   bit m_df[2], m_sf[2];
   int maxv[2] = '{255, 3};

   function automatic bit f_disc(input logic [3:0] x);
      bit m, u, p, c;
      {m, u, p, c} = x;
      return p || (u && c);
   endfunction

   function automatic bit f_stl(input logic [3:0] x);
      bit m, u, p, c;
      {m, u, p, c} = x;
      return (u && !(p || m)) || !(m || u || c);
   endfunction

   function automatic int bump(input int v, input bit inc, input int mx);
      return (inc && v < mx) ? v + 1 : v;
   endfunction

   initial begin
      for (int k = 0; k < 2; k++) begin
         m_st[k] = S_IDLE; m_item[k] = 0; m_disc[k] = 0; m_stl[k] = 0;
         m_df[k] = 0; m_sf[k] = 0;
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_df[k] = 0;
         m_sf[k] = 0;
         if (reset) begin
            m_st[k] = S_IDLE; m_item[k] = 0; m_disc[k] = 0; m_stl[k] = 0;
         end else begin
            case (m_st[k])
               S_IDLE: if (start) begin
                  m_item[k] = 0; m_disc[k] = 0; m_stl[k] = 0; m_st[k] = S_SCAN;
               end
               S_SCAN: begin
                  bit d, s;
                  d = f_disc(item_upc);
                  s = f_stl(item_upc);
                  if (item_valid) begin
                     m_item[k] = bump(m_item[k], 1'b1, maxv[k]);
                     m_disc[k] = bump(m_disc[k], d, maxv[k]);
                     m_stl[k]  = bump(m_stl[k], s, maxv[k]);
                     m_df[k] = d;
                     m_sf[k] = s;
                  end
                  if (item_valid && s && m_stl[k] >= TH) m_st[k] = S_ALARM;
                  else if (done) m_st[k] = S_TOTAL;
               end
               S_ALARM: if (clear_alarm) m_st[k] = S_SCAN;
               default: m_st[k] = S_IDLE;
            endcase
         end
      end
   end

   // Compare every output of both lanes against the model each cycle
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("a_ready", 32'(a_ready), 32'(m_st[0] == S_SCAN));
         chk("a_busy",  32'(a_busy),  32'(m_st[0] != S_IDLE));
         chk("a_alarm", 32'(a_alarm), 32'(m_st[0] == S_ALARM));
         chk("a_total", 32'(a_tv),    32'(m_st[0] == S_TOTAL));
         chk("a_dflag", 32'(a_df),    32'(m_df[0]));
         chk("a_sflag", 32'(a_sf),    32'(m_sf[0]));
         chk("a_item",  32'(a_item),  32'(m_item[0]));
         chk("a_disc",  32'(a_disc),  32'(m_disc[0]));
         chk("a_stl",   32'(a_stl),   32'(m_stl[0]));
         chk("b_ready", 32'(b_ready), 32'(m_st[1] == S_SCAN));
         chk("b_busy",  32'(b_busy),  32'(m_st[1] != S_IDLE));
         chk("b_alarm", 32'(b_alarm), 32'(m_st[1] == S_ALARM));
         chk("b_total", 32'(b_tv),    32'(m_st[1] == S_TOTAL));
         chk("b_dflag", 32'(b_df),    32'(m_df[1]));
         chk("b_sflag", 32'(b_sf),    32'(m_sf[1]));
         chk("b_item",  32'(b_item),  32'(m_item[1]));
         chk("b_disc",  32'(b_disc),  32'(m_disc[1]));
         chk("b_stl",   32'(b_stl),   32'(m_stl[1]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drv(input bit s, input bit d, input bit c, input bit v, input logic [3:0] u);
      start = s; done = d; clear_alarm = c; item_valid = v; item_upc = u;
      @(negedge clk);
   endtask

   task automatic idle_c();
      drv(0, 0, 0, 0, 4'h0);
   endtask

   task automatic item(input logic [3:0] u);
      drv(0, 0, 0, 1, u);
   endtask

   task automatic clr_if_alarm();
      if (m_st[0] == S_ALARM) drv(0, 0, 1, 0, 4'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_c();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 0; done = 0; clear_alarm = 0; item_valid = 0; item_upc = 0;
      @(negedge clk);
      @(negedge clk);
      cmp_en = 1'b1;
      reset = 1'b0;
      chk("rst_busy",  32'(a_busy), 0);
      chk("rst_item",  32'(a_item), 0);
      chk("rst_ready", 32'(a_ready), 0);

      // Session 1: P, U+C, M then done
      drv(1, 0, 0, 0, 4'h0);
      chk("t1_ready", 32'(a_ready), 1);
      item(4'b0010);
      chk("t1_dflag", 32'(a_df), 1);
      chk("t1_sflag", 32'(a_sf), 1);
      item(4'b0101);
      item(4'b1000);
      chk("t1_dflag_m", 32'(a_df), 0);
      drv(0, 1, 0, 0, 4'h0);
      chk("t1_tv",   32'(a_tv), 1);
      chk("t1_disc", 32'(a_disc), 2);
      chk("t1_stl",  32'(a_stl), 2);
      chk("t1_item", 32'(a_item), 3);
      idle_c();
      chk("t1_tv_off", 32'(a_tv), 0);
      chk("t1_hold",   32'(a_item), 3);
      chk("t1_idle",   32'(a_busy), 0);

      // Session 2: alarm trip at the third stolen item
      drv(1, 0, 0, 0, 4'h0);
      item(4'b0100);
      item(4'b0000);
      item(4'b0110);
      chk("t2_stl2",  32'(a_stl), 2);
      chk("t2_noalm", 32'(a_alarm), 0);
      item(4'b0100);
      chk("t2_stl3",  32'(a_stl), 3);
      chk("t2_alarm", 32'(a_alarm), 1);
      chk("t2_nrdy",  32'(a_ready), 0);
      drv(0, 1, 0, 1, 4'b0100);
      chk("t2_done_ign", 32'(a_alarm), 1);
      chk("t2_stl_hold", 32'(a_stl), 3);
      drv(0, 0, 1, 0, 4'h0);
      chk("t2_cleared", 32'(a_alarm), 0);
      chk("t2_rdy",     32'(a_ready), 1);
      drv(0, 1, 0, 0, 4'h0);
      idle_c();

      // Session 3: all 16 codes
      drv(1, 0, 0, 0, 4'h0);
      for (int code = 0; code < 16; code++) begin
         item(4'(code));
         clr_if_alarm();
      end
      drv(0, 1, 0, 0, 4'h0);
      chk("t3_tv",     32'(a_tv), 1);
      chk("t3_item",   32'(a_item), 16);
      chk("t3_disc",   32'(a_disc), 10);
      chk("t3_stl",    32'(a_stl), 4);
      chk("t3_b_item", 32'(b_item), 3);
      chk("t3_b_stl",  32'(b_stl), 3);
      idle_c();

      // Session 4: saturation of the 2-bit lane
      drv(1, 0, 0, 0, 4'h0);
      for (int n = 0; n < 5; n++) begin
         item(4'b0010);
         clr_if_alarm();
      end
      drv(0, 1, 0, 0, 4'h0);
      chk("t4_b_item", 32'(b_item), 3);
      chk("t4_b_disc", 32'(b_disc), 3);
      chk("t4_a_item", 32'(a_item), 5);
      chk("t4_a_disc", 32'(a_disc), 5);
      idle_c();

      // Session 5: start in SCAN ignored; accept together with done
      drv(1, 0, 0, 0, 4'h0);
      item(4'b1000);
      drv(1, 0, 0, 1, 4'b0001);
      chk("t5_nostart", 32'(a_item), 2);
      drv(0, 1, 0, 1, 4'b1000);
      chk("t5_tv",   32'(a_tv), 1);
      chk("t5_item", 32'(a_item), 3);
      idle_c();

      // Session 6: reset in ALARM and mid-SCAN
      drv(1, 0, 0, 0, 4'h0);
      item(4'b0100);
      item(4'b0000);
      item(4'b0010);
      chk("t6_alarm", 32'(a_alarm), 1);
      do_reset();
      chk("t6_alm0", 32'(a_alarm), 0);
      chk("t6_stl0", 32'(a_stl), 0);
      chk("t6_bsy0", 32'(a_busy), 0);
      drv(1, 0, 0, 0, 4'h0);
      item(4'b1000);
      do_reset();
      chk("t6_item0", 32'(a_item), 0);
      chk("t6_rdy0",  32'(a_ready), 0);

      // Random traffic
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         drv($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
             4'($urandom_range(0, 15)));
      end
      reset = 1'b0;
      idle_c();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
